// File: rtl/demux_pkg.sv
// Shared constants for the 1:2 demultiplexer with per-channel FIFOs.
package demux_pkg;

    localparam int DATA_W_DEF = 2;

    localparam logic CH0 = 1'b0;
    localparam logic CH1 = 1'b1;

    localparam int                STAT_W   = 8;
    localparam logic [STAT_W-1:0] STAT_MAX = 8'd255;

endpackage

// File: rtl/demux_fifo.sv
// Show-ahead synchronous FIFO used as one channel buffer of demux1_2_fifo.
// Storage is not reset; only pointers and occupancy clear on reset_L.
module demux_fifo #(
    parameter int DATA_W     = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset_L,
    input  logic              push,
    input  logic [DATA_W-1:0] din,
    input  logic              pop,
    output logic [DATA_W-1:0] dout,
    output logic              empty,
    output logic              full
);

    localparam int ADDR_W = $clog2(FIFO_DEPTH);

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count;
    logic              do_push;
    logic              do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (ADDR_W+1)'(FIFO_DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = empty ? '0 : mem[rd_ptr];

    // Pointers wrap naturally because FIFO_DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + ADDR_W'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + ADDR_W'(1);
            if (do_push && !do_pop)
                count <= count + (ADDR_W+1)'(1);
            else if (do_pop && !do_push)
                count <= count - (ADDR_W+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/demux1_2_fifo.sv
// 1:2 demultiplexer steering one input stream into two buffered output lanes.
// Optional per-channel accepted-word counters when DEMUX_STATS_EN is defined.
module demux1_2_fifo
    import demux_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset_L,
    input  logic              selector,
    input  logic [DATA_W-1:0] data_in,
    input  logic              valid_in,
    output logic              ready_in,
    output logic [DATA_W-1:0] data_out0,
    output logic              valid_out0,
    input  logic              ready_out0,
    output logic [DATA_W-1:0] data_out1,
    output logic              valid_out1,
    input  logic              ready_out1,
    output logic              full0,
    output logic              full1
`ifdef DEMUX_STATS_EN
    ,
    input  logic              stat_clr,
    output logic [STAT_W-1:0] stat_cnt0,
    output logic [STAT_W-1:0] stat_cnt1
`endif
);

    logic empty0;
    logic empty1;
    logic push0;
    logic push1;
    logic pop0;
    logic pop1;

    // Acceptance depends only on the selected channel being full: no pass-through.
    assign ready_in   = (selector == CH1) ? !full1 : !full0;
    assign push0      = valid_in && ready_in && (selector == CH0);
    assign push1      = valid_in && ready_in && (selector == CH1);
    assign valid_out0 = !empty0;
    assign valid_out1 = !empty1;
    assign pop0       = valid_out0 && ready_out0;
    assign pop1       = valid_out1 && ready_out1;

    demux_fifo #(
        .DATA_W    (DATA_W),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo0 (
        .clk    (clk),
        .reset_L(reset_L),
        .push   (push0),
        .din    (data_in),
        .pop    (pop0),
        .dout   (data_out0),
        .empty  (empty0),
        .full   (full0)
    );

    demux_fifo #(
        .DATA_W    (DATA_W),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo1 (
        .clk    (clk),
        .reset_L(reset_L),
        .push   (push1),
        .din    (data_in),
        .pop    (pop1),
        .dout   (data_out1),
        .empty  (empty1),
        .full   (full1)
    );

`ifdef DEMUX_STATS_EN
    // Saturating accepted-word counters; a synchronous clear beats an increment.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            stat_cnt0 <= '0;
            stat_cnt1 <= '0;
        end else if (stat_clr) begin
            stat_cnt0 <= '0;
            stat_cnt1 <= '0;
        end else begin
            if (push0 && (stat_cnt0 != STAT_MAX))
                stat_cnt0 <= stat_cnt0 + STAT_W'(1);
            if (push1 && (stat_cnt1 != STAT_MAX))
                stat_cnt1 <= stat_cnt1 + STAT_W'(1);
        end
    end
`endif

endmodule

// File: doc/demux1_2_fifo.md
Name: demux1_2_fifo

Overview:
1:2 demultiplexer. It is the receive-side counterpart of the registered 2:1 mux. A single DATA_W-bit input stream is steered by `selector` into one of two per-channel FIFOs. Each channel presents its own valid/ready output stream to downstream logic. The block sits after the mux stage and splits a merged lane back into two lanes, with buffering and backpressure.

Parameters:
DATA_W, 2, width of each data word
FIFO_DEPTH, 4, entries per channel FIFO; must be a power of 2 and at least 2
ADDR_W, $clog2(FIFO_DEPTH), pointer width (derived; do not override)

Ports:
clk  input  1  single clock; everything is on posedge
reset_L  input  1  asynchronous, active-low reset
selector  input  1  0 routes the input to channel 0, 1 routes it to channel 1
data_in  input  DATA_W  input word
valid_in  input  1  data_in is valid
ready_in  output  1  block can accept the word on the selected channel
data_out0  output  DATA_W  channel 0 head word
valid_out0  output  1  channel 0 FIFO not empty
ready_out0  input  1  downstream accepts the channel 0 word
data_out1  output  DATA_W  channel 1 head word
valid_out1  output  1  channel 1 FIFO not empty
ready_out1  input  1  downstream accepts the channel 1 word
full0, full1  output  1 each  channel FIFO full

Behaviour:
- Reset: reset_L low clears, asynchronously, all pointers and occupancy counts.
  - valid_out0/1 = 0, data_out0/1 = 0, full0/1 = 0.
  - FIFO storage is not reset.
  - Asserting reset mid-operation discards all buffered words.
- Input handshake:
  - ready_in = !full[selector], combinational from selector and registered state.
  - A push occurs when valid_in && ready_in at posedge. The word goes to the tail of FIFO[selector].
  - ready_in depends only on full. A full channel refuses input even if the same cycle pops it; there is no pass-through.
  - valid_in must stay asserted, with data_in and selector held stable, until accepted.
- Output (show-ahead):
  - valid_outN = !emptyN.
  - data_outN = head entry when valid_outN is 1, otherwise 0.
  - A pop occurs when valid_outN && ready_outN at posedge.
- Latency: a word pushed at edge k is visible on data_outN/valid_outN after edge k. Minimum residence is one cycle, with no combinational input-to-output path.
- Ordering: strict FIFO order per channel. There is no ordering relation between channels.
- Occupancy per channel:
  - push only: count +1.
  - pop only: count -1.
  - push and pop in the same cycle: count unchanged and pointers both advance (possible only when 0 < count < FIFO_DEPTH).
- Pointers wrap modulo FIFO_DEPTH. fullN = (countN == FIFO_DEPTH), emptyN = (countN == 0).
- Channels operate independently. Both channels may pop in the same cycle while the other channel receives a push.
- ready_outN while empty: ignored, no state change.
- valid_in low: no push, regardless of selector.

Optional Feature:
Macro DEMUX_STATS_EN.
- Defined:
  - Adds output ports `stat_cnt0` and `stat_cnt1`, each 8 bits. They count words accepted per channel, saturate at 255, and are cleared by reset_L.
  - Adds input `stat_clr`, a synchronous clear; clear wins over a simultaneous increment.
- Undefined: these ports and the counters are absent, and the datapath is unchanged.

Decomposition:
- Package `demux_pkg`:
  - DATA_W default.
  - Channel index constants CH0 = 1'b0 and CH1 = 1'b1.
  - Stats counter width of 8 and its saturation value of 255.
- Sub-module `demux_fifo`: one per channel.
  - Show-ahead synchronous FIFO with ports push, din, pop, dout, empty, full.
  - Parameters DATA_W and FIFO_DEPTH; async active-low reset on clk/reset_L.
- The top level holds only the routing logic, the ready_in mux and the optional stats.

Test Plan:
1. Reset: hold reset_L low for 3 cycles, then release, with valid_in driven high throughout. → All valid_out = 0, data_out = 0, full = 0 during reset; no words are stored.
2. Routing and order: push 2'b01, 2'b10 with selector=0, then 2'b11 with selector=1; ready_out0 = ready_out1 = 1. → Channel 0 outputs 01 then 10; channel 1 outputs 11; each word appears one cycle after its push.
3. Full / backpressure: ready_out0 = 0; push 5 words to channel 0 with FIFO_DEPTH = 4. → full0 = 1 after the 4th push; ready_in = 0 with selector=0 and ready_in = 1 with selector=1; the 5th word is held and accepted only after one channel 0 pop.
4. Simultaneous push/pop and wrap: keep channel 1 at 2 entries while pushing and popping every cycle for 10 cycles. → Count stays 2, data order is preserved across pointer wrap, and full1 never asserts.
5. Reset mid-operation: fill channel 0 with 3 words, then pulse reset_L low asynchronously between clock edges. → valid_out0 drops immediately; after release, channel 0 is empty and the next push of 2'b10 is the first word out.
6. With DEMUX_STATS_EN defined: push 260 words to channel 0, then assert stat_clr together with a push. → stat_cnt0 saturates at 255, reads 0 after the clear, and stat_cnt1 = 0 throughout.
